// File: rtl/booth_mul_if.sv
// Request/response bus of the pipelined Booth multiplier.
// The `word` signal exists only when MUL_WORD_EN is defined.
interface booth_mul_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             rs1_sign;
  logic             rs2_sign;
  logic             hi_sel;
  logic [TAG_W-1:0] in_tag;
`ifdef MUL_WORD_EN
  logic             word;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

`ifdef MUL_WORD_EN
  modport master (output in_valid, rs1_data, rs2_data, rs1_sign, rs2_sign, hi_sel, in_tag, word,
                  output out_ready, input in_ready, out_valid, out_data, out_tag);
  modport slave  (input  in_valid, rs1_data, rs2_data, rs1_sign, rs2_sign, hi_sel, in_tag, word,
                  input  out_ready, output in_ready, out_valid, out_data, out_tag);
`else
  modport master (output in_valid, rs1_data, rs2_data, rs1_sign, rs2_sign, hi_sel, in_tag,
                  output out_ready, input in_ready, out_valid, out_data, out_tag);
  modport slave  (input  in_valid, rs1_data, rs2_data, rs1_sign, rs2_sign, hi_sel, in_tag,
                  input  out_ready, output in_ready, out_valid, out_data, out_tag);
`endif
endinterface

// File: rtl/booth_mul_pipe.sv
// 3-stage radix-4 Booth / Wallace multiplier (MUL/MULH/MULHSU/MULHU), tag pass-through, flushable.
// Optional MUL_WORD_EN adds the RV64 MULW `word` mode (requires XLEN=64).
module booth_mul_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  booth_mul_if.slave bus
);
  localparam int STAGES = 3;
  localparam int NPP    = XLEN/2 + 1;
  localparam int OW     = XLEN + 2;
  localparam int W      = 2*XLEN + 4;
  localparam int NR     = NPP + 1;
  localparam int LVL    = 2*$clog2(NR);

  typedef struct packed {
    logic             hi;
    logic             word;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  logic [STAGES:1] vld_pipe;
  logic            stall, adv, acc;

  assign stall         = vld_pipe[3] && !bus.out_ready;
  assign adv           = !stall;
  assign acc           = bus.in_valid && adv;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[3];

  always_ff @(posedge clock) begin
    if (reset || flush) vld_pipe <= '0;
    else if (adv)       vld_pipe <= {vld_pipe[STAGES-1:1], acc};
  end

  // ---------------- operand select + S1 ----------------
  logic            word_op;
  logic [XLEN-1:0] opa, opb;
`ifdef MUL_WORD_EN
  assign word_op = bus.word;
  always_comb begin
    opa = bus.rs1_data;
    opb = bus.rs2_data;
    if (word_op) begin
      opa = {{(XLEN-32){bus.rs1_sign & bus.rs1_data[31]}}, bus.rs1_data[31:0]};
      opb = {{(XLEN-32){bus.rs2_sign & bus.rs2_data[31]}}, bus.rs2_data[31:0]};
    end
  end
`else
  assign word_op = 1'b0;
  assign opa     = bus.rs1_data;
  assign opb     = bus.rs2_data;
`endif

  logic [OW-1:0] s1_x, s1_y;
  ctl_t          s1_ctl;

  always_ff @(posedge clock) begin
    if (adv) begin
      s1_x   <= {{2{bus.rs1_sign & opa[XLEN-1]}}, opa};
      s1_y   <= {{2{bus.rs2_sign & opb[XLEN-1]}}, opb};
      s1_ctl <= '{hi: bus.hi_sel, word: word_op, tag: bus.in_tag};
    end
  end

  // Booth rows; the +1 of each negated row goes into a shared extra row at bit 2i
  logic [W-1:0] pp [NR];

  always_comb begin : booth_rows
    logic [OW:0]   yz;
    logic [2:0]    dig;
    logic [OW-1:0] mag;
    logic          neg;
    yz     = {s1_y, 1'b0};
    pp[NPP] = '0;
    for (int i = 0; i < NPP; i++) begin
      dig = yz[2*i+2 -: 3];
      case (dig)
        3'b001, 3'b010: begin mag = s1_x;      neg = 1'b0; end
        3'b011:         begin mag = s1_x << 1; neg = 1'b0; end
        3'b100:         begin mag = s1_x << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = s1_x;      neg = 1'b1; end
        default:        begin mag = '0;        neg = 1'b0; end
      endcase
      if (neg) mag = ~mag;
      pp[i] = {{(W-OW){mag[OW-1]}}, mag} << (2*i);
      pp[NPP][2*i] = neg;
    end
  end

  // Wallace reduction: each level compresses every full group of three rows with 3:2 CSAs
  logic [W-1:0] sum_d, car_d;

  always_comb begin : wallace
    logic [W-1:0] cur [NR];
    logic [W-1:0] nxt [NR];
    int n, m;
    cur = pp;
    n   = NR;
    for (int l = 0; l < LVL; l++) begin
      nxt = cur;
      m   = 0;
      if (n > 2) begin
        for (int g = 0; g < NR/3; g++) begin
          if (3*g+2 < n) begin
            nxt[m]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[m+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                        (cur[3*g+1] & cur[3*g+2])) << 1;
            m += 2;
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (r >= 3*(n/3) && r < n) begin
            nxt[m] = cur[r];
            m += 1;
          end
        end
        n = m;
      end
      cur = nxt;
    end
    sum_d = cur[0];
    car_d = cur[1];
  end

  // ---------------- S2 ----------------
  logic [2*XLEN-1:0] s2_sum, s2_car;
  ctl_t              s2_ctl;

  always_ff @(posedge clock) begin
    if (adv) begin
      s2_sum <= sum_d[2*XLEN-1:0];
      s2_car <= car_d[2*XLEN-1:0];
      s2_ctl <= s1_ctl;
    end
  end

  // Rows are extended past 2*XLEN only to keep the sign math exact; the result is mod 2^(2*XLEN)
  logic unused_bits;
  assign unused_bits = ^{sum_d[W-1:2*XLEN], car_d[W-1:2*XLEN], s2_ctl.word};

  // ---------------- S3: CPA + select ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res;

  assign prod = s2_sum + s2_car;

  always_comb begin
    res = s2_ctl.hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef MUL_WORD_EN
    if (s2_ctl.word) res = {{(XLEN-32){prod[31]}}, prod[31:0]};
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_data <= '0;
      bus.out_tag  <= '0;
    end else if (adv) begin
      bus.out_data <= vld_pipe[2] ? res        : '0;
      bus.out_tag  <= vld_pipe[2] ? s2_ctl.tag : '0;
    end
  end
endmodule
